// File: rtl/phy_rx_link_ctrl.sv
// Link bring-up sequencer for the two-lane PHY receive path: lane reset, lock wait,
// lane-to-lane skew check, running-link supervision and bounded retry.
module phy_rx_link_ctrl #(
   parameter int RST_HOLD     = 4,
   parameter int LOCK_TIMEOUT = 64,
   parameter int SKEW_MAX     = 2,
   parameter int RETRY_MAX    = 3
) (
   input  logic       clk_f,
   input  logic       reset,
   input  logic       enable,
   input  logic       active0,
   input  logic       active1,
   input  logic       valid_in0,
   input  logic       valid_in1,
   output logic       lane_reset,
   output logic       datapath_en,
   output logic       link_up,
   output logic       link_fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   localparam int TIMER_W = $clog2(LOCK_TIMEOUT + RST_HOLD);
   localparam int SKEW_W  = $clog2(SKEW_MAX + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LANE_RST  = 3'd1,
      WAIT_LOCK = 3'd2,
      DESKEW    = 3'd3,
      UP        = 3'd4,
      FAIL      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [SKEW_W-1:0]  skew_q, skew_d;
   logic               first_lane_q, first_lane_d;   // 0 = lane 0 locked first
   logic               mismatch_q, mismatch_d;
   logic [1:0]         retry_q, retry_d;
   logic               retry;
   logic               first_active;
   logic               other_active;

   assign first_active = first_lane_q ? active1 : active0;
   assign other_active = first_lane_q ? active0 : active1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_f or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         skew_q       <= '0;
         first_lane_q <= 1'b0;
         mismatch_q   <= 1'b0;
         retry_q      <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         skew_q       <= skew_d;
         first_lane_q <= first_lane_d;
         mismatch_q   <= mismatch_d;
         retry_q      <= retry_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      skew_d       = skew_q;
      first_lane_d = first_lane_q;
      mismatch_d   = 1'b0;
      retry_d      = retry_q;
      retry        = 1'b0;

      case (state_q)
         IDLE: begin
            retry_d = '0;
            timer_d = '0;
            if (enable) state_d = LANE_RST;
         end
         LANE_RST: begin
            if (timer_q == TIMER_W'(RST_HOLD - 1)) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (active0 && active1) begin
               state_d = UP;
            end else if (active0 ^ active1) begin
               state_d      = DESKEW;
               skew_d       = '0;
               first_lane_d = active1;
            end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
               retry = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         DESKEW: begin
            // A first-lane drop outranks the second lane arriving on the same cycle.
            if (!first_active) begin
               retry = 1'b1;
            end else if (other_active) begin
               state_d = UP;
            end else if (skew_q == SKEW_W'(SKEW_MAX - 1)) begin
               retry = 1'b1;
            end else begin
               skew_d = skew_q + SKEW_W'(1);
            end
         end
         UP: begin
            mismatch_d = valid_in0 ^ valid_in1;
            if (!(active0 && active1)) retry = 1'b1;
            else if (mismatch_d && mismatch_q) retry = 1'b1;
         end
         FAIL: ;
         default: state_d = IDLE;
      endcase

      if (!enable) begin
         state_d = IDLE;
         timer_d = '0;
      end else if (retry) begin
         if (retry_q == 2'(RETRY_MAX)) begin
            state_d = FAIL;
         end else begin
            retry_d = retry_q + 2'd1;
            state_d = LANE_RST;
            timer_d = '0;
         end
      end
   end

   // Moore outputs decode the registered state, so an async reset clears them at once.
   assign lane_reset  = (state_q == WAIT_LOCK) || (state_q == DESKEW) || (state_q == UP);
   assign datapath_en = (state_q == UP);
   assign link_up     = (state_q == UP);
   assign link_fail   = (state_q == FAIL);
   assign retry_cnt   = retry_q;
   assign state       = state_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl: directed bring-up scenarios plus a
// randomized run checked against a phase/age reference model.
module tb_phy_rx_link_ctrl;

   localparam int RST_HOLD     = 4;
   localparam int LOCK_TIMEOUT = 64;
   localparam int SKEW_MAX     = 2;
   localparam int RETRY_MAX    = 3;

   localparam int P_IDLE = 0, P_LR = 1, P_WL = 2, P_DS = 3, P_UP = 4, P_FAIL = 5;

   logic       clk_f = 1'b0;
   logic       reset, enable, active0, active1, valid_in0, valid_in1;
   logic       lane_reset, datapath_en, link_up, link_fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   // Reference model: current phase, cycles spent in it, and link history.
   int m_phase, m_age, m_first, m_mis_run, m_retries;

   phy_rx_link_ctrl #(
      .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .SKEW_MAX(SKEW_MAX), .RETRY_MAX(RETRY_MAX)
   ) dut (
      .clk_f(clk_f), .reset(reset), .enable(enable),
      .active0(active0), .active1(active1),
      .valid_in0(valid_in0), .valid_in1(valid_in1),
      .lane_reset(lane_reset), .datapath_en(datapath_en),
      .link_up(link_up), .link_fail(link_fail),
      .retry_cnt(retry_cnt), .state(state)
   );

   always #5 clk_f = ~clk_f;

   task automatic model_reset();
      m_phase = P_IDLE; m_age = 0; m_first = 0; m_mis_run = 0; m_retries = 0;
   endtask

   task automatic model_step();
      int nxt     = m_phase;
      int retries = m_retries;
      bit retry   = 1'b0;
      bit a0      = (active0 === 1'b1);
      bit a1      = (active1 === 1'b1);
      bit mis     = (valid_in0 !== valid_in1);
      case (m_phase)
         P_IDLE: begin
            retries = 0;
            if (enable) nxt = P_LR;
         end
         P_LR: if (m_age + 1 >= RST_HOLD) nxt = P_WL;
         P_WL: begin
            if (a0 && a1) nxt = P_UP;
            else if (a0 || a1) begin nxt = P_DS; m_first = a1 ? 1 : 0; end
            else if (m_age + 1 >= LOCK_TIMEOUT) retry = 1'b1;
         end
         P_DS: begin
            if (!(m_first == 1 ? a1 : a0)) retry = 1'b1;
            else if (m_first == 1 ? a0 : a1) nxt = P_UP;
            else if (m_age + 1 >= SKEW_MAX) retry = 1'b1;
         end
         P_UP: begin
            if (!(a0 && a1)) retry = 1'b1;
            else if (mis && m_mis_run >= 1) retry = 1'b1;
         end
         default: nxt = m_phase;
      endcase
      if (!enable) nxt = P_IDLE;
      else if (retry) begin
         if (retries == RETRY_MAX) nxt = P_FAIL;
         else begin retries++; nxt = P_LR; end
      end
      m_mis_run = (m_phase == P_UP && mis) ? m_mis_run + 1 : 0;
      m_age     = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase   = nxt;
      m_retries = retries;
   endtask

   function automatic logic [8:0] model_vec();
      logic lr = (m_phase == P_WL) || (m_phase == P_DS) || (m_phase == P_UP);
      return {lr, m_phase == P_UP, m_phase == P_UP, m_phase == P_FAIL, 2'(m_retries), 3'(m_phase)};
   endfunction

   function automatic logic [8:0] dut_vec();
      return {lane_reset, datapath_en, link_up, link_fail, retry_cnt, state};
   endfunction

   // One rising edge; outputs are observed 1 time unit later.
   task automatic step();
      @(posedge clk_f);
      model_step();
      #1;
   endtask

   task automatic go_idle();
      enable = 1'b0; active0 = 1'b0; active1 = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
      step(); step();
   endtask

   task automatic to_wait_lock();
      enable = 1'b1;
      repeat (1 + RST_HOLD) step();
   endtask

   task automatic bring_up();
      to_wait_lock();
      active0 = 1'b1; active1 = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; active0 = 1'b0; active1 = 1'b0;
      valid_in0 = 1'b0; valid_in1 = 1'b0;
      model_reset();
      #12;
      checks++;
      if (dut_vec() !== 9'd0) begin
         errors++; $display("FAIL reset_values: got %b want %b", dut_vec(), 9'd0);
      end
      reset = 1'b1;
      step(); step();
      checks++;
      if (state !== 3'd0 || lane_reset !== 1'b0) begin
         errors++; $display("FAIL idle_hold: got state=%0d lane_reset=%b want 0 0", state, lane_reset);
      end
   endtask

   task automatic test_bring_up();
      int lr_cycles = 0;
      enable = 1'b1;
      step();
      for (int i = 0; i < 20 && state === 3'd1; i++) begin
         checks++;
         if (lane_reset !== 1'b0) begin
            errors++; $display("FAIL lane_rst_low: got %b want 0", lane_reset);
         end
         lr_cycles++;
         step();
      end
      checks++;
      if (lr_cycles != RST_HOLD || state !== 3'd2 || lane_reset !== 1'b1) begin
         errors++;
         $display("FAIL lane_rst_len: got cycles=%0d state=%0d lane_reset=%b want %0d 2 1",
                  lr_cycles, state, lane_reset, RST_HOLD);
      end
      repeat (9) step();
      checks++;
      if (state !== 3'd2 || link_up !== 1'b0) begin
         errors++; $display("FAIL wait_lock_hold: got state=%0d link_up=%b want 2 0", state, link_up);
      end
      active0 = 1'b1; active1 = 1'b1;
      step();
      checks++;
      if (state !== 3'd4 || link_up !== 1'b1 || datapath_en !== 1'b1 || retry_cnt !== 2'd0) begin
         errors++;
         $display("FAIL bring_up_up: got state=%0d link_up=%b dp_en=%b retry=%0d want 4 1 1 0",
                  state, link_up, datapath_en, retry_cnt);
      end
   endtask

   task automatic test_deskew();
      go_idle();
      to_wait_lock();
      active0 = 1'b1;
      step();
      checks++;
      if (state !== 3'd3) begin
         errors++; $display("FAIL deskew_enter: got state=%0d want 3", state);
      end
      active1 = 1'b1;
      step();
      checks++;
      if (state !== 3'd4 || link_up !== 1'b1) begin
         errors++; $display("FAIL deskew_t1_up: got state=%0d link_up=%b want 4 1", state, link_up);
      end
      go_idle();
      to_wait_lock();
      active0 = 1'b1;
      step();
      step();
      step();
      active1 = 1'b1;
      checks++;
      if (state !== 3'd1 || retry_cnt !== 2'd1 || lane_reset !== 1'b0) begin
         errors++;
         $display("FAIL deskew_late: got state=%0d retry=%0d lane_reset=%b want 1 1 0",
                  state, retry_cnt, lane_reset);
      end
      step();
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL deskew_late_hold: got state=%0d want 1", state);
      end
   endtask

   task automatic test_timeout_fail();
      int n = 0;
      go_idle();
      enable = 1'b1;
      while (state !== 3'd5 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (n != 1 + (RETRY_MAX + 1) * (RST_HOLD + LOCK_TIMEOUT)) begin
         errors++; $display("FAIL fail_latency: got %0d edges want %0d", n,
                            1 + (RETRY_MAX + 1) * (RST_HOLD + LOCK_TIMEOUT));
      end
      step(); step();
      checks++;
      if (state !== 3'd5 || link_fail !== 1'b1 || retry_cnt !== 2'd3 || lane_reset !== 1'b0) begin
         errors++;
         $display("FAIL fail_state: got state=%0d link_fail=%b retry=%0d lane_reset=%b want 5 1 3 0",
                  state, link_fail, retry_cnt, lane_reset);
      end
      enable = 1'b0;
      step();
      checks++;
      if (state !== 3'd0 || link_fail !== 1'b0 || retry_cnt !== 2'd3) begin
         errors++;
         $display("FAIL fail_exit: got state=%0d link_fail=%b retry=%0d want 0 0 3",
                  state, link_fail, retry_cnt);
      end
      step();
      checks++;
      if (retry_cnt !== 2'd0) begin
         errors++; $display("FAIL idle_clear: got retry=%0d want 0", retry_cnt);
      end
   endtask

   task automatic test_valid_mismatch();
      go_idle();
      bring_up();
      valid_in0 = 1'b1; valid_in1 = 1'b0;
      step();
      valid_in1 = 1'b1;
      step();
      checks++;
      if (state !== 3'd4 || datapath_en !== 1'b1) begin
         errors++; $display("FAIL single_mismatch: got state=%0d dp_en=%b want 4 1", state, datapath_en);
      end
      valid_in1 = 1'b0;
      step();
      checks++;
      if (state !== 3'd4) begin
         errors++; $display("FAIL mismatch_first: got state=%0d want 4", state);
      end
      step();
      checks++;
      if (state !== 3'd1 || datapath_en !== 1'b0 || retry_cnt !== 2'd1) begin
         errors++;
         $display("FAIL double_mismatch: got state=%0d dp_en=%b retry=%0d want 1 0 1",
                  state, datapath_en, retry_cnt);
      end
   endtask

   task automatic test_lock_loss_and_abort();
      go_idle();
      bring_up();
      active1 = 1'b0;
      step();
      checks++;
      if (state !== 3'd1 || link_up !== 1'b0) begin
         errors++; $display("FAIL lock_loss: got state=%0d link_up=%b want 1 0", state, link_up);
      end
      active0 = 1'b0;
      repeat (RST_HOLD) step();
      active1 = 1'b1;
      step();
      checks++;
      if (state !== 3'd3) begin
         errors++; $display("FAIL abort_deskew_enter: got state=%0d want 3", state);
      end
      enable = 1'b0;
      step();
      checks++;
      if (state !== 3'd0 || lane_reset !== 1'b0) begin
         errors++; $display("FAIL abort_deskew: got state=%0d lane_reset=%b want 0 0", state, lane_reset);
      end
   endtask

   task automatic test_async_reset();
      go_idle();
      bring_up();
      #3 reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== 9'd0) begin
         errors++; $display("FAIL async_reset: got %b want %b", dut_vec(), 9'd0);
      end
      #2 reset = 1'b1;
      step();
      checks++;
      if (state !== 3'd1 || retry_cnt !== 2'd0) begin
         errors++; $display("FAIL restart: got state=%0d retry=%0d want 1 0", state, retry_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 11) == 0) active0 = ~active0;
         if ($urandom_range(0, 11) == 0) active1 = ~active1;
         valid_in0 = 1'($urandom);
         valid_in1 = ($urandom_range(0, 5) == 0) ? ~valid_in0 : valid_in0;
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b want %b (lr,dp,up,fail,retry,state)",
                     i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_bring_up();
      test_deskew();
      test_timeout_fail();
      test_valid_mismatch();
      test_lock_loss_and_abort();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
